// File: rtl/memory_dumper_pkg.sv
// Shared widths and FSM state encodings for the memory dumper.
// Imported by the dumper RTL; the bench picks its own widths explicitly.
package memory_dumper_pkg;

    localparam int WORD_SIZE_DEF     = 16;
    localparam int MEM_ADDR_SIZE_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/memory_dumper.sv
// Streams a contiguous RAM region out over a valid/ready port after CPU halt.
// Latency: first word valid 3 cycles after start_dump; one word per 3 cycles with out_ready high.
// Backpressure: out_data/out_addr held in SEND until out_ready; no further RAM reads are issued meanwhile.
module memory_dumper
    import memory_dumper_pkg::*;
#(
    parameter int WORD_SIZE     = WORD_SIZE_DEF,
    parameter int MEM_ADDR_SIZE = MEM_ADDR_SIZE_DEF,
    parameter int CNT_SIZE      = MEM_ADDR_SIZE + 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start_dump,
    input  logic                     abort,
    input  logic [MEM_ADDR_SIZE-1:0] base_addr,
    input  logic [CNT_SIZE-1:0]      word_count,
    output logic [MEM_ADDR_SIZE-1:0] mem_addr,
    output logic                     mem_read,
    input  logic [WORD_SIZE-1:0]     mem_read_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_SIZE-1:0]     out_data,
    output logic [MEM_ADDR_SIZE-1:0] out_addr,
    output logic                     busy,
    output logic                     done
);

    dump_state_t                state, state_nxt;
    logic [MEM_ADDR_SIZE-1:0]   cur_addr;
    logic [CNT_SIZE-1:0]        remaining;
    logic [MEM_ADDR_SIZE-1:0]   mem_addr_q;
    logic                       handshake;

    assign handshake = (state == SEND) && out_ready && !abort;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cur_addr   <= '0;
            remaining  <= '0;
            mem_addr_q <= '0;
            out_data   <= '0;
            out_addr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start_dump) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
            end
            // Remember the issued address so mem_addr holds outside READ.
            if (state == READ) begin
                mem_addr_q <= cur_addr;
            end
            if (state == WAIT) begin
                out_data <= mem_read_data;
                out_addr <= cur_addr;
            end
            if (handshake) begin
                cur_addr  <= cur_addr + MEM_ADDR_SIZE'(1);
                remaining <= remaining - CNT_SIZE'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_dump) begin
                    state_nxt = (word_count == '0) ? DONE : READ;
                end
            end
            READ: state_nxt = WAIT;
            WAIT: state_nxt = SEND;
            SEND: begin
                if (out_ready) begin
                    state_nxt = (remaining == CNT_SIZE'(1)) ? DONE : READ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Abort wins over a handshake landing in the same cycle.
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
    end

    assign mem_read  = (state == READ);
    assign mem_addr  = (state == READ) ? cur_addr : mem_addr_q;
    assign out_valid = (state == SEND);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_memory_dumper.sv
// Directed bench for memory_dumper with a one-cycle-latency RAM model.
module tb_memory_dumper;

    localparam int WS = 16;
    localparam int AS = 8;
    localparam int CS = AS + 1;

    logic          clock;
    logic          reset;
    logic          start_dump;
    logic          abort;
    logic [AS-1:0] base_addr;
    logic [CS-1:0] word_count;
    logic [AS-1:0] mem_addr;
    logic          mem_read;
    logic [WS-1:0] mem_read_data;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] out_data;
    logic [AS-1:0] out_addr;
    logic          busy;
    logic          done;

    logic [WS-1:0] ram [256];
    int            rd_cnt;
    int            checks;
    int            errors;
    int            rd_mark;

    memory_dumper #(.WORD_SIZE(WS), .MEM_ADDR_SIZE(AS), .CNT_SIZE(CS)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_dump    (start_dump),
        .abort         (abort),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .mem_addr      (mem_addr),
        .mem_read      (mem_read),
        .mem_read_data (mem_read_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_addr      (out_addr),
        .busy          (busy),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM read data appears the cycle after mem_read.
    always @(posedge clock) begin
        if (mem_read) begin
            mem_read_data <= ram[mem_addr];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rd_cnt        = 0;
        mem_read_data = '0;
        for (int i = 0; i < 256; i++) ram[i] = 16'hA000 | 16'(i);
        ram[4]   = 16'h00AA;
        ram[5]   = 16'h00BB;
        ram[6]   = 16'h00CC;
        ram[255] = 16'hF0F0;
        ram[0]   = 16'h0F0F;

        reset = 1'b0; start_dump = 1'b0; abort = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_count = '0;
        step(); step();
        chk("rst_mem_read",  32'(mem_read),  0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_done",      32'(done),      0);
        chk("rst_mem_addr",  32'(mem_addr),  0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_addr",  32'(out_addr),  0);
        reset = 1'b1;
        step();

        // Three words, ready held high: 3-cycle spacing then done.
        base_addr = 8'd4; word_count = 9'd3; out_ready = 1'b1; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        chk("t1_rd0_en",   32'(mem_read), 1);
        chk("t1_rd0_addr", 32'(mem_addr), 4);
        chk("t1_busy",     32'(busy),     1);
        step();
        chk("t1_wait_rd",   32'(mem_read), 0);
        chk("t1_wait_hold", 32'(mem_addr), 4);
        step();
        chk("t1_w0_vld",  32'(out_valid), 1);
        chk("t1_w0_data", 32'(out_data),  'h00AA);
        chk("t1_w0_addr", 32'(out_addr),  4);
        step();
        chk("t1_rd1_addr", 32'(mem_addr), 5);
        step(); step();
        chk("t1_w1_data", 32'(out_data), 'h00BB);
        chk("t1_w1_addr", 32'(out_addr), 5);
        step(); step(); step();
        chk("t1_w2_vld",  32'(out_valid), 1);
        chk("t1_w2_data", 32'(out_data),  'h00CC);
        chk("t1_w2_addr", 32'(out_addr),  6);
        step();
        chk("t1_done",     32'(done),      1);
        chk("t1_done_vld", 32'(out_valid), 0);
        step();
        chk("t1_idle_done", 32'(done), 0);
        chk("t1_idle_busy", 32'(busy), 0);

        // Zero-length dump goes straight to DONE.
        rd_mark = rd_cnt;
        base_addr = 8'd9; word_count = 9'd0; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        chk("t2_done",  32'(done),      1);
        chk("t2_rd",    32'(mem_read),  0);
        chk("t2_vld",   32'(out_valid), 0);
        step();
        chk("t2_after", 32'(done), 0);
        chk("t2_nord",  32'(rd_cnt - rd_mark), 0);

        // Backpressure: word held for 5 cycles, no extra reads.
        rd_mark = rd_cnt;
        out_ready = 1'b0; base_addr = 8'd5; word_count = 9'd1; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        step(); step();
        chk("t3_vld0", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_vld",  32'(out_valid), 1);
            chk("t3_hold_data", 32'(out_data),  'h00BB);
            chk("t3_hold_rd",   32'(mem_read),  0);
        end
        chk("t3_reads", 32'(rd_cnt - rd_mark), 1);
        out_ready = 1'b1;
        step();
        chk("t3_done", 32'(done), 1);
        step();

        // Address wrap at the top of memory.
        base_addr = 8'hFF; word_count = 9'd2; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        chk("t4_rd0_addr", 32'(mem_addr), 'hFF);
        step(); step();
        chk("t4_w0_addr", 32'(out_addr), 'hFF);
        chk("t4_w0_data", 32'(out_data), 'hF0F0);
        step();
        chk("t4_rd1_addr", 32'(mem_addr), 0);
        step(); step();
        chk("t4_w1_addr", 32'(out_addr), 0);
        chk("t4_w1_data", 32'(out_data), 'h0F0F);
        step();
        chk("t4_done", 32'(done), 1);
        step();

        // Abort on the second of four words, coincident with ready.
        base_addr = 8'd8; word_count = 9'd4; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        step(); step(); step(); step(); step();
        chk("t5_w1_data", 32'(out_data), 'hA009);
        abort = 1'b1;
        step(); abort = 1'b0;
        chk("t5_busy", 32'(busy),      0);
        chk("t5_vld",  32'(out_valid), 0);
        chk("t5_done", 32'(done),      0);
        step();
        chk("t5_done2", 32'(done), 0);
        base_addr = 8'd6; word_count = 9'd1; start_dump = 1'b1;
        step(); start_dump = 1'b0;
        chk("t5_new_rd",   32'(mem_read), 1);
        chk("t5_new_addr", 32'(mem_addr), 6);
        step(); step();
        chk("t5_new_data", 32'(out_data), 'h00CC);
        step();
        chk("t5_new_done", 32'(done), 1);
        step();

        // start_dump while busy is ignored; reset mid-dump clears everything.
        base_addr = 8'd4; word_count = 9'd3; start_dump = 1'b1;
        step();
        base_addr = 8'd0; word_count = 9'd0;
        step(); start_dump = 1'b0;
        step();
        chk("t6_ign_addr", 32'(out_addr), 4);
        chk("t6_ign_data", 32'(out_data), 'h00AA);
        step();
        chk("t6_rd1", 32'(mem_addr), 5);
        reset = 1'b0;
        step();
        chk("t6_rst_rd",    32'(mem_read),  0);
        chk("t6_rst_vld",   32'(out_valid), 0);
        chk("t6_rst_busy",  32'(busy),      0);
        chk("t6_rst_done",  32'(done),      0);
        chk("t6_rst_maddr", 32'(mem_addr),  0);
        chk("t6_rst_data",  32'(out_data),  0);
        chk("t6_rst_oaddr", 32'(out_addr),  0);
        reset = 1'b1;
        step();
        chk("t6_post_done", 32'(done), 0);
        chk("t6_post_busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
